// File: rtl/sprite_linebuf.sv
// Double-buffered sprite line buffer. The sprite engine draws into the back
// bank with first-opaque-wins priority. The front bank is scanned out at
// hcount and cleared one cycle behind the beam. The banks swap at every line
// wrap, so pixels drawn on line N are shown on line N+1.
module sprite_linebuf #(
    parameter int AW      = 9,
    parameter int DW      = 8,
    parameter int HACTIVE = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [8:0]    hcount,
    input  logic          hb,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_x,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] pix,
    output logic          bank,
    output logic          init_done
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Control state
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          init_done_q, init_done_d;
    logic [8:0]    hc_prev_q, hc_prev_d;
    logic          bank_q, bank_d;
    logic [DW-1:0] pix_q, pix_d;

    // Clear-behind: address and bank latched together with the display read
    logic          clr_v_q, clr_v_d;
    logic [AW-1:0] clr_a_q, clr_a_d;
    logic          clr_bank_q, clr_bank_d;

    // Draw pipeline stage S1
    logic          s1_v_q, s1_v_d;
    logic [AW-1:0] s1_x_q, s1_x_d;
    logic [DW-1:0] s1_data_q, s1_data_d;
    logic          s1_bank_q, s1_bank_d;
    logic [DW-1:0] s1_old_q, s1_old_d;

    // Last write committed to each bank. S0 reads the array before the
    // write of the same cycle lands, so S1 patches its stale old value here.
    logic [1:0]         pw_v_q, pw_v_d;
    logic [1:0][AW-1:0] pw_a_q, pw_a_d;
    logic [1:0][DW-1:0] pw_d_q, pw_d_d;

    // Storage: one read port and one write port per bank
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];

    logic          swap;
    logic          accept;
    logic [AW-1:0] hc_addr;
    logic [DW-1:0] front_rd;
    logic [DW-1:0] back_rd;
    logic          s1_fwd;
    logic [DW-1:0] s1_old_eff;
    logic          s1_we;
    logic [1:0]         we;
    logic [1:0][AW-1:0] wa;
    logic [1:0][DW-1:0] wd;

    // Next-state: init sweep, swap detect, display read and draw stage S0
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        hc_prev_d   = hcount;
        bank_d      = bank_q;
        pix_d       = '0;
        clr_v_d     = 1'b0;
        clr_a_d     = clr_a_q;
        clr_bank_d  = clr_bank_q;
        s1_v_d      = 1'b0;
        s1_x_d      = s1_x_q;
        s1_data_d   = s1_data_q;
        s1_bank_d   = s1_bank_q;
        s1_old_d    = s1_old_q;
        hc_addr     = AW'(hcount);
        swap        = 1'b0;
        accept      = 1'b0;
        front_rd    = '0;
        back_rd     = '0;

        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == '1) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                swap   = (hcount == 9'd0) && (hc_prev_q != 9'd0);
                bank_d = bank_q ^ swap;

                // Front bank is the post-swap bank, back bank is the other one
                front_rd = bank_d ? mem1[hc_addr] : mem0[hc_addr];
                back_rd  = bank_d ? mem0[wr_x]    : mem1[wr_x];

                if (!hb && (32'(hcount) < HACTIVE)) begin
                    pix_d      = front_rd;
                    clr_v_d    = 1'b1;
                    clr_a_d    = hc_addr;
                    clr_bank_d = bank_d;
                end

                accept = wr_en && (32'(wr_x) < HACTIVE) && (wr_data != '0);
                if (accept) begin
                    s1_v_d    = 1'b1;
                    s1_x_d    = wr_x;
                    s1_data_d = wr_data;
                    s1_bank_d = ~bank_d;
                    s1_old_d  = back_rd;
                end
            end
        endcase
    end

    // Stage S1 resolution and per-bank write port selection
    always_comb begin
        s1_fwd     = pw_v_q[s1_bank_q] && (pw_a_q[s1_bank_q] == s1_x_q);
        s1_old_eff = s1_fwd ? pw_d_q[s1_bank_q] : s1_old_q;
        s1_we      = s1_v_q && (s1_old_eff == '0);
        we         = '0;
        wa         = '0;
        wd         = '0;
        for (int b = 0; b < 2; b++) begin
            if (state_q == ST_INIT) begin
                we[b] = 1'b1;
                wa[b] = cnt_q;
            end else if (clr_v_q && (clr_bank_q == 1'(b))) begin
                we[b] = 1'b1;
                wa[b] = clr_a_q;
            end else if (s1_we && (s1_bank_q == 1'(b))) begin
                we[b] = 1'b1;
                wa[b] = s1_x_q;
                wd[b] = s1_data_q;
            end
        end
        pw_v_d = we;
        pw_a_d = wa;
        pw_d_d = wd;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            hc_prev_q   <= '0;
            bank_q      <= 1'b0;
            pix_q       <= '0;
            clr_v_q     <= 1'b0;
            clr_a_q     <= '0;
            clr_bank_q  <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_x_q      <= '0;
            s1_data_q   <= '0;
            s1_bank_q   <= 1'b0;
            s1_old_q    <= '0;
            pw_v_q      <= '0;
            pw_a_q      <= '0;
            pw_d_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            hc_prev_q   <= hc_prev_d;
            bank_q      <= bank_d;
            pix_q       <= pix_d;
            clr_v_q     <= clr_v_d;
            clr_a_q     <= clr_a_d;
            clr_bank_q  <= clr_bank_d;
            s1_v_q      <= s1_v_d;
            s1_x_q      <= s1_x_d;
            s1_data_q   <= s1_data_d;
            s1_bank_q   <= s1_bank_d;
            s1_old_q    <= s1_old_d;
            pw_v_q      <= pw_v_d;
            pw_a_q      <= pw_a_d;
            pw_d_q      <= pw_d_d;
        end
    end

    // Bank 0 write port (contents are not reset; the init sweep clears them)
    always_ff @(posedge clk) begin
        if (we[0]) begin
            mem0[wa[0]] <= wd[0];
        end
    end

    // Bank 1 write port
    always_ff @(posedge clk) begin
        if (we[1]) begin
            mem1[wa[1]] <= wd[1];
        end
    end

    assign pix       = pix_q;
    assign bank      = bank_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Directed bench for sprite_linebuf: drives an hcount 0..335 timing pattern,
// schedules sprite writes from a table, captures each displayed line and
// compares against hand-computed expected pixels, counts and bank values.
module tb_sprite_linebuf;

    localparam int AW      = 9;
    localparam int DW      = 8;
    localparam int HACTIVE = 256;
    localparam int HTOTAL  = 336;
    localparam int NLINES  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [8:0]    hcount = '0;
    logic          hb = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_x = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] pix;
    logic          bank;
    logic          init_done;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    sprite_linebuf #(.AW(AW), .DW(DW), .HACTIVE(HACTIVE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .hb        (hb),
        .wr_en     (wr_en),
        .wr_x      (wr_x),
        .wr_data   (wr_data),
        .pix       (pix),
        .bank      (bank),
        .init_done (init_done)
    );

    typedef struct {
        int line;
        int hc;
        int x;
        int data;
    } wr_vec_t;

    typedef struct {
        int line;
        int x;
        int exp_pix;
    } chk_vec_t;

    wr_vec_t  wr_tab[$];
    chk_vec_t chk_tab[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] cap [NLINES][HACTIVE];
    int            nz [NLINES];
    logic          bank_at0 [NLINES];
    logic          bank_end [NLINES];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hold hcount at 0 and keep a write strobe active (it must be ignored)
    // while counting cycles until init_done rises.
    task automatic init_wait();
        int n;
        int nzp;
        n   = 0;
        nzp = 0;
        hcount  = '0;
        hb      = 1'b0;
        wr_en   = 1'b1;
        wr_x    = AW'(77);
        wr_data = 8'h99;
        while (!init_done && n < 600) begin
            tick();
            n++;
            if (pix != '0) nzp++;
        end
        check("init_cycles", n, 512);
        check("init_pix_zero", nzp, 0);
    endtask

    // Drive one scan line; optionally pulse reset when hcount reaches rst_at.
    task automatic run_line(input int ln, input int rst_at);
        nz[ln] = 0;
        for (int h = 0; h < HTOTAL; h++) begin
            hcount  = 9'(h);
            hb      = (h >= HACTIVE);
            wr_en   = 1'b0;
            wr_x    = '0;
            wr_data = '0;
            foreach (wr_tab[i]) begin
                if (wr_tab[i].line == ln && wr_tab[i].hc == h) begin
                    wr_en   = 1'b1;
                    wr_x    = AW'(wr_tab[i].x);
                    wr_data = DW'(wr_tab[i].data);
                end
            end
            if (h == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("midline_rst_pix", pix, 0);
                check("midline_rst_bank", bank, 0);
                check("midline_rst_init_done", init_done, 0);
                @(posedge clk);
                #1;
                rst_n   = 1'b1;
                hcount  = '0;
                hb      = 1'b0;
                wr_en   = 1'b0;
                return;
            end
            tick();
            if (h < HACTIVE) cap[ln][h] = pix;
            if (pix != '0) nz[ln]++;
            if (h == 0) bank_at0[ln] = bank;
            if (h == HTOTAL - 1) bank_end[ln] = bank;
        end
    endtask

    int exp_nz   [NLINES] = '{0, 1, 3, 2, 0, 1, 0, 0};
    int exp_bank [NLINES] = '{0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        // write schedule: line, hcount when driven, x, data
        wr_tab.push_back('{0,  20,  10, 8'h25});  // basic draw
        wr_tab.push_back('{1,  50,  40, 8'h11});  // back-to-back priority
        wr_tab.push_back('{1,  51,  40, 8'h22});
        wr_tab.push_back('{1, 100,  20, 8'h00});  // transparent drop
        wr_tab.push_back('{1, 101, 300, 8'h33});  // out of range drop
        wr_tab.push_back('{1, 102, 255, 8'h55});  // last visible x
        wr_tab.push_back('{1, 103, 256, 8'h66});  // first invisible x
        wr_tab.push_back('{1, 300, 250, 8'h77});  // drawn during hblank
        wr_tab.push_back('{2,   0,   5, 8'h44});  // swap-cycle write
        wr_tab.push_back('{2,  60,  40, 8'h11});  // priority with 5-cycle gap
        wr_tab.push_back('{2,  65,  40, 8'h22});
        wr_tab.push_back('{4,  10,  60, 8'h3C});  // shown before mid-line reset
        wr_tab.push_back('{4,  20, 200, 8'h3D});  // pending past reset point
        wr_tab.push_back('{5, 100,  30, 8'h5A});  // pending back-bank writes
        wr_tab.push_back('{5, 127,  31, 8'h5B});

        // expected pixels: line, x, value
        chk_tab.push_back('{1,  10, 8'h25});
        chk_tab.push_back('{1,  77, 8'h00});
        chk_tab.push_back('{2,  10, 8'h00});
        chk_tab.push_back('{2,  40, 8'h11});
        chk_tab.push_back('{2,  20, 8'h00});
        chk_tab.push_back('{2, 255, 8'h55});
        chk_tab.push_back('{2, 250, 8'h77});
        chk_tab.push_back('{2,   0, 8'h00});
        chk_tab.push_back('{2,   5, 8'h00});
        chk_tab.push_back('{3,   5, 8'h44});
        chk_tab.push_back('{3,  40, 8'h11});
        chk_tab.push_back('{3,  10, 8'h00});
        chk_tab.push_back('{5,  60, 8'h3C});
        chk_tab.push_back('{6,  60, 8'h00});
        chk_tab.push_back('{7,  30, 8'h00});

        // reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_pix", pix, 0);
        check("reset_bank", bank, 0);
        check("reset_init_done", init_done, 0);

        rst_n = 1'b1;
        init_wait();

        for (int ln = 0; ln < 5; ln++) run_line(ln, -1);
        run_line(5, 128);
        init_wait();
        run_line(6, -1);
        run_line(7, -1);

        foreach (chk_tab[i]) begin
            check($sformatf("pix_line%0d_x%0d", chk_tab[i].line, chk_tab[i].x),
                  cap[chk_tab[i].line][chk_tab[i].x], chk_tab[i].exp_pix);
        end

        for (int ln = 0; ln < NLINES; ln++) begin
            check($sformatf("nonzero_count_line%0d", ln), nz[ln], exp_nz[ln]);
            check($sformatf("bank_at_hc0_line%0d", ln), bank_at0[ln], exp_bank[ln]);
            if (ln != 5) begin
                check($sformatf("bank_at_hc335_line%0d", ln), bank_end[ln], exp_bank[ln]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_linebuf.md
Name: sprite_linebuf

Overview:
- Double-buffered (ping-pong) sprite line buffer. It sits directly downstream of the video timing generator and consumes its hcount/hb.
- The sprite engine draws into the back bank with first-written-wins priority. The front bank is scanned out at hcount and cleared behind the beam.
- Banks swap at each line wrap, so sprites drawn during line N appear on line N+1.

Parameters:
- AW, 9, x address width; each bank holds 2^AW entries.
- DW, 8, pixel width (palette index); value 0 = transparent.
- HACTIVE, 256, number of visible pixels; x >= HACTIVE is never stored or shown.

Ports:
- clk  in  1  pixel clock, same as the timing generator
- rst_n  in  1  asynchronous active-low reset
- hcount  in  9  horizontal counter from the timing generator
- hb  in  1  horizontal blank from the timing generator
- wr_en  in  1  sprite pixel write strobe, accepted every cycle
- wr_x  in  AW  sprite pixel x position
- wr_data  in  DW  sprite pixel value
- pix  out  DW  registered sprite pixel for the current hcount
- bank  out  1  index of the front (display) bank
- init_done  out  1  high once the post-reset clear sweep is complete

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: pix=0, bank=0, init_done=0.
  - Internal state: FSM=INIT, clear counter=0, write pipeline invalid, hcount_d=0.
- Memory contents are not reset directly. INIT clears them.
- FSM INIT:
  - Each cycle, write 0 to address cnt in both banks, then cnt++.
  - After address 2^AW-1 is written, go to RUN on the next cycle and set init_done=1.
  - Duration is exactly 2^AW cycles.
  - In INIT, wr_en is ignored and pix=0.
- FSM RUN: remains in RUN until reset. Reset mid-line or mid-write restarts INIT.
- Swap detect:
  - swap = (hcount==0) && (hcount_d!=0), where hcount_d is hcount registered.
  - On swap, bank toggles in the same cycle that pix samples the new line.
  - The first swap after reset is evaluated only in RUN.
- Display path (front bank = bank after any swap this cycle):
  - pix <= (!hb && hcount<HACTIVE) ? front[hcount] : 0. Latency is 1 clk.
  - Clear-behind: one cycle after a read of address A, write 0 to front[A]. The clear uses the bank latched with the read, so a clear issued across a swap still hits the old front bank.
  - Entries at or above HACTIVE are never cleared. They are never written either (see below).
- Draw path, 2-stage read-modify-write on the back bank:
  - S0: if wr_en && wr_x<HACTIVE && wr_data!=0, read back[wr_x]. Latch x, data and the target bank (= !bank after any swap this cycle).
  - Otherwise the write is dropped; zero data never overwrites.
  - S1: the stored value is old. If S1 of the previous cycle wrote the same x and the same bank, old is forwarded from that data instead.
  - S1 writes data only if old==0, so the first opaque pixel wins.
  - A write accepted on the swap cycle targets the new back bank. A write in S1 at swap completes to its latched bank.
- Port conflicts:
  - Draw and display always target different banks, except a stale S1 write to the bank that just became front at swap. Allow it: one pixel at most, at x written during the last cycle of the line.
  - Each bank needs one read port and one write port.
- Widths:
  - hcount compares use the full 9 bits.
  - wr_x is zero-extended to 9 bits for the HACTIVE compare.

Test Plan:
- Reset then hold rst_n=1 -> init_done rises exactly 512 clk after release, pix=0 throughout, and all entries of both banks read 0.
- Run the timing generator (hcount 0..335). On line N write x=10 data=0x25 -> line N+1: pix=0x25 on the cycle after hcount=10, 0 elsewhere. Line N+2: pix=0 at x=10 (cleared behind).
- Priority: write x=40 data=0x11 on cycle t, then x=40 data=0x22 on cycle t+1 (forwarding path) -> next line shows 0x11. Repeat with a 5-cycle gap -> still 0x11.
- Transparent and out-of-range drops: write data=0x00 at x=20 over an empty entry; write x=300 data=0x33 -> next line pix=0 at x=20; no 0x33 appears and no other entry changes.
- Swap boundary: write x=5 data=0x44 on the swap cycle (hcount 335->0) -> appears on the following line, not the current one. bank toggles exactly on the hcount==0 cycle.
- Assert rst_n=0 for 1 clk at hcount=128 with pending writes -> pix=0 and bank=0 immediately, a full INIT sweep follows, and no pre-reset pixel is ever displayed.
